// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Fills the Y86 instruction memory from a framed byte stream before the SEQ
// core is released. Frame layout:
//   SYNC, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, LEN payload bytes, CSUM
// where addr = {ADDR_HI[1:0],ADDR_LO}, len = {LEN_HI[2:0],LEN_LO},
// LEN_HI[7] marks the last frame, and CSUM is the XOR of ADDR_LO through the
// last payload byte. A good last frame parks the loader in RUN (cpu_run=1);
// any header or checksum fault parks it in ERR (load_err=1). Both are
// terminal until reset.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_data   byte stream source
//   in_ready            registered accept flag (transfer = in_valid & in_ready)
//   wr_en/addr/data     one-cycle-per-byte instruction memory write port
//   cpu_run             load complete, core may fetch from PC=0
//   load_err            sticky frame error
//   frame_cnt           good-frame count, wraps 255 -> 0
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int          MEM_BYTES = 1024,
    parameter int          AW        = 10,
    parameter logic [7:0]  SYNC      = 8'hA5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          cpu_run,
    output logic          load_err,
    output logic [7:0]    frame_cnt
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_CSUM = 3'd3;
    localparam logic [2:0] S_RUN  = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    // Header arithmetic is 12 bits wide so addr+len can exceed the memory
    // size without wrapping back into range.
    localparam logic [11:0] MEM_END = 12'(MEM_BYTES);

    logic [2:0]    state;
    logic [2:0]    state_next;
    logic [1:0]    hdr_idx;
    logic [7:0]    addr_lo;
    logic [7:0]    addr_hi;
    logic [7:0]    len_lo;
    logic [7:0]    csum;
    logic          last;
    logic [AW-1:0] ptr;
    logic [10:0]   remaining;

    logic          accept;
    logic [10:0]   hdr_len;
    logic [11:0]   hdr_end;
    logic          hdr_bad;

    assign accept = in_valid & in_ready;

    // Header validation is evaluated while LEN_HI is on the bus, so the
    // length's upper bits come straight from in_data.
    assign hdr_len = {in_data[2:0], len_lo};
    assign hdr_end = {2'b00, addr_hi[1:0], addr_lo} + {1'b0, hdr_len};
    assign hdr_bad = (addr_hi[7:2] != 6'd0)
                   || (hdr_len == 11'd0)
                   || ({1'b0, hdr_len} > MEM_END)
                   || (hdr_end > MEM_END);

    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves it unassigned would infer a latch.
    always_comb begin
        state_next = state;
        if (accept) begin
            case (state)
                S_IDLE: if (in_data == SYNC) state_next = S_HDR;
                S_HDR:  if (hdr_idx == 2'd3) state_next = hdr_bad ? S_ERR : S_DATA;
                S_DATA: if (remaining == 11'd1) state_next = S_CSUM;
                S_CSUM: begin
                    if (in_data == csum) state_next = last ? S_RUN : S_IDLE;
                    else                 state_next = S_ERR;
                end
                default: state_next = state;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            hdr_idx   <= 2'd0;
            addr_lo   <= 8'd0;
            addr_hi   <= 8'd0;
            len_lo    <= 8'd0;
            csum      <= 8'd0;
            last      <= 1'b0;
            ptr       <= '0;
            remaining <= 11'd0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= 8'd0;
            frame_cnt <= 8'd0;
        end else begin
            state <= state_next;
            // Registered from the next state: no path from in_valid to in_ready.
            in_ready <= (state_next < S_RUN);
            wr_en    <= 1'b0;

            if (accept) begin
                case (state)
                    S_IDLE: begin
                        hdr_idx <= 2'd0;
                        csum    <= 8'd0;
                    end
                    S_HDR: begin
                        csum    <= csum ^ in_data;
                        hdr_idx <= hdr_idx + 2'd1;
                        case (hdr_idx)
                            2'd0: addr_lo <= in_data;
                            2'd1: addr_hi <= in_data;
                            2'd2: len_lo  <= in_data;
                            default: begin
                                last      <= in_data[7];
                                ptr       <= AW'({addr_hi[1:0], addr_lo});
                                remaining <= hdr_len;
                            end
                        endcase
                    end
                    S_DATA: begin
                        wr_en     <= 1'b1;
                        wr_addr   <= ptr;
                        wr_data   <= in_data;
                        csum      <= csum ^ in_data;
                        ptr       <= ptr + 1'b1;
                        remaining <= remaining - 11'd1;
                    end
                    S_CSUM: begin
                        if (in_data == csum) frame_cnt <= frame_cnt + 8'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cpu_run  = (state == S_RUN);
    assign load_err = (state == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader. Frames are built by the bench, which
// computes the checksum itself and pushes each expected (addr, data) write
// into a scoreboard queue; a negedge monitor pops and compares every wr_en
// strobe and tracks the length of the last continuous strobe run.
// ---------------------------------------------------------------------------
module tb_imem_loader;

    localparam logic [7:0] SYNC = 8'hA5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic       cpu_run;
    logic       load_err;
    logic [7:0] frame_cnt;

    imem_loader #(.MEM_BYTES(1024), .AW(10), .SYNC(SYNC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cpu_run   (cpu_run),
        .load_err  (load_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] pay_q[$];
    wr_t        exp_w;
    int         vectors = 0;
    int         errors  = 0;
    int         wr_run  = 0;
    int         last_run = 0;

    // {in_ready, cpu_run, load_err, frame_cnt}
    function automatic logic [10:0] status();
        return {in_ready, cpu_run, load_err, frame_cnt};
    endfunction

    // Write-port monitor / scoreboard consumer.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wr_run++;
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: wr_addr=%h wr_data=%h, required no write", wr_addr, wr_data);
            end else begin
                exp_w = exp_q.pop_front();
                if (wr_addr !== exp_w.addr || wr_data !== exp_w.data) begin
                    errors++;
                    $display("FAIL wr_port: addr=%h data=%h, required addr=%h data=%h",
                             wr_addr, wr_data, exp_w.addr, exp_w.data);
                end
            end
        end else if (wr_run != 0) begin
            last_run = wr_run;
            wr_run   = 0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        t = 0;
        repeat (gap) begin
            @(negedge clk);
            in_data = 8'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            vectors++;
            errors++;
            $display("FAIL ready_timeout: in_ready=0 for byte %h, required 1", b);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    // Sends one frame; payload comes from pay_q first, then random bytes.
    // csum_ovr < 0 sends the correct checksum, otherwise that value.
    task automatic send_frame(input logic [9:0] addr, input int len, input logic lst,
                              input int gap_max, input int csum_ovr);
        logic [7:0] hdr[4];
        logic [7:0] x;
        logic [7:0] d;
        logic [10:0] l;
        l = 11'(len);
        hdr[0] = addr[7:0];
        hdr[1] = {6'd0, addr[9:8]};
        hdr[2] = l[7:0];
        hdr[3] = {lst, 4'd0, l[10:8]};
        x = 8'h00;
        send_byte(SYNC, $urandom_range(gap_max, 0));
        for (int i = 0; i < 4; i++) begin
            x ^= hdr[i];
            send_byte(hdr[i], $urandom_range(gap_max, 0));
        end
        for (int i = 0; i < len; i++) begin
            if (pay_q.size() != 0) d = pay_q.pop_front();
            else                   d = 8'($urandom);
            x ^= d;
            exp_q.push_back({10'(addr + 10'(i)), d});
            send_byte(d, $urandom_range(gap_max, 0));
        end
        send_byte((csum_ovr < 0) ? x : 8'(csum_ovr), $urandom_range(gap_max, 0));
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        last_run = 0;
    endtask

    task automatic check_status(input string name, input logic [10:0] want);
        vectors++;
        if (status() !== want) begin
            errors++;
            $display("FAIL %s: {rdy,run,err,cnt}=%b_%b_%b_%h, required %b_%b_%b_%h", name,
                     status()[10], status()[9], status()[8], status()[7:0],
                     want[10], want[9], want[8], want[7:0]);
        end
    endtask

    task automatic check_drained(input string name);
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d writes outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        check_status("reset_status", 11'b000_0000_0000);
        vectors++;
        if ({wr_en, wr_addr, wr_data} !== 19'd0) begin
            errors++;
            $display("FAIL reset_wr: en=%b addr=%h data=%h, required 0 0 0", wr_en, wr_addr, wr_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_status("ready_after_reset", {3'b100, 8'd0});
    endtask

    task automatic test_single_last();
        apply_reset();
        pay_q.push_back(8'h30);
        pay_q.push_back(8'hF4);
        pay_q.push_back(8'h00);
        send_frame(10'h000, 3, 1'b1, 0, -1);
        check_status("single_last_status", {3'b010, 8'd1});
        repeat (2) @(negedge clk);
        vectors++;
        if (last_run != 3) begin
            errors++;
            $display("FAIL single_last_run: strobe run=%0d, required 3", last_run);
        end
        check_status("single_last_hold", {3'b010, 8'd1});
        check_drained("single_last_writes");
    endtask

    task automatic test_two_frames();
        apply_reset();
        send_frame(10'h010, 2, 1'b0, 3, -1);
        check_status("frame1_idle", {3'b100, 8'd1});
        send_byte(8'h55, 2);
        @(negedge clk);
        check_status("garbage_discard", {3'b100, 8'd1});
        send_frame(10'h3FE, 2, 1'b1, 3, -1);
        check_status("frame2_run", {3'b010, 8'd2});
        repeat (2) @(negedge clk);
        check_drained("two_frames_writes");
    endtask

    task automatic bounds_case(input string name, input logic [7:0] lo, input logic [7:0] hi,
                               input logic [7:0] ll, input logic [7:0] lh);
        apply_reset();
        send_byte(SYNC, 0);
        send_byte(lo, 0);
        send_byte(hi, 0);
        send_byte(ll, 0);
        check_status({name, "_pre"}, {3'b100, 8'd0});
        send_byte(lh, 0);
        check_status(name, {3'b001, 8'd0});
        repeat (3) @(negedge clk);
        check_status({name, "_hold"}, {3'b001, 8'd0});
    endtask

    task automatic test_bounds();
        bounds_case("bounds_end", 8'hFF, 8'h03, 8'h02, 8'h80);
        bounds_case("bounds_addr_hi", 8'h00, 8'h04, 8'h02, 8'h80);
        bounds_case("bounds_len0", 8'h00, 8'h00, 8'h00, 8'h80);
    endtask

    task automatic test_csum_err();
        apply_reset();
        send_frame(10'h040, 3, 1'b0, 1, -1);
        check_status("csum_good_first", {3'b100, 8'd1});
        pay_q.push_back(8'h10);
        send_frame(10'h020, 1, 1'b0, 0, 0);
        check_status("csum_err", {3'b001, 8'd1});
        repeat (2) @(negedge clk);
        check_drained("csum_err_writes");
    endtask

    task automatic test_reset_mid_data();
        apply_reset();
        send_byte(SYNC, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        send_byte(8'h80, 0);
        exp_q.push_back({10'h100, 8'h11});
        send_byte(8'h11, 0);
        exp_q.push_back({10'h101, 8'h22});
        send_byte(8'h22, 0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_status("mid_reset_status", 11'd0);
        vectors++;
        if ({wr_en, wr_addr, wr_data} !== 19'd0) begin
            errors++;
            $display("FAIL mid_reset_wr: en=%b addr=%h data=%h, required 0 0 0", wr_en, wr_addr, wr_data);
        end
        check_drained("mid_reset_partial");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(10'h100, 4, 1'b1, 1, -1);
        check_status("after_reset_frame", {3'b010, 8'd1});
        repeat (2) @(negedge clk);
        check_drained("after_reset_writes");
    endtask

    task automatic test_full_mem();
        apply_reset();
        send_frame(10'h000, 1024, 1'b1, 0, -1);
        check_status("full_mem_status", {3'b010, 8'd1});
        repeat (2) @(negedge clk);
        vectors++;
        if (last_run != 1024) begin
            errors++;
            $display("FAIL full_mem_run: strobe run=%0d, required 1024", last_run);
        end
        check_drained("full_mem_writes");
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_last();
        test_two_frames();
        test_bounds();
        test_csum_err();
        test_reset_mid_data();
        test_full_mem();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
